// File: rtl/matrix_index_sequencer_pkg.sv
// Shared types for the matrix index sequencer: FSM state encoding and default index width.
package mm_pkg;

  localparam int MM_IDX_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mm_state_e;

endpackage

// File: rtl/matrix_index_sequencer_if.sv
// Control/index bundle between a matrix-multiply controller (master) and the index sequencer (slave).
interface matrix_index_sequencer_if
  import mm_pkg::*;
#(
  parameter int WIDTH = MM_IDX_WIDTH
) ();

  logic             start;
  logic             stall;
  logic [WIDTH-1:0] limit_i;
  logic [WIDTH-1:0] limit_j;
  logic [WIDTH-1:0] limit_k;
  logic [WIDTH-1:0] idx_i;
  logic [WIDTH-1:0] idx_j;
  logic [WIDTH-1:0] idx_k;
  logic             valid;
  logic             first_k;
  logic             last_k;
  logic             busy;
  logic             done;

  modport master (
    output start, stall, limit_i, limit_j, limit_k,
    input  idx_i, idx_j, idx_k, valid, first_k, last_k, busy, done
  );

  modport slave (
    input  start, stall, limit_i, limit_j, limit_k,
    output idx_i, idx_j, idx_k, valid, first_k, last_k, busy, done
  );

endinterface

// File: rtl/matrix_index_sequencer_wrap_counter.sv
// Single loop-index counter: counts 0..limit inclusive and flags the wrap so counters can be chained.
module wrap_counter
  import mm_pkg::*;
#(
  parameter int WIDTH = MM_IDX_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             load_zero,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_limit;

  assign w_at_limit = (r_count == limit);
  assign wrap       = en & w_at_limit;
  assign count      = r_count;

  // Wrap is an explicit compare, so a limit of all-ones never relies on overflow.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_count <= '0;
    end else if (load_zero) begin
      r_count <= '0;
    end else if (en) begin
      if (w_at_limit) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_index_sequencer.sv
// Three-level (i outer, j, k inner) loop-index generator for the matrix multiply datapath.
module matrix_index_sequencer
  import mm_pkg::*;
#(
  parameter int WIDTH = MM_IDX_WIDTH
) (
  input logic                     clk,
  input logic                     clr,
  matrix_index_sequencer_if.slave bus
);

  mm_state_e        r_state;
  mm_state_e        w_state_nxt;
  logic [WIDTH-1:0] r_lim_i;
  logic [WIDTH-1:0] r_lim_j;
  logic [WIDTH-1:0] r_lim_k;
  logic [WIDTH-1:0] w_idx_i;
  logic [WIDTH-1:0] w_idx_j;
  logic [WIDTH-1:0] w_idx_k;
  logic             w_run;
  logic             w_accept;
  logic             w_advance;
  logic             w_wrap_k;
  logic             w_wrap_j;
  logic             w_wrap_i;
  logic             w_load_zero;

  assign w_run       = (r_state == ST_RUN);
  assign w_accept    = (r_state == ST_IDLE) & bus.start;
  assign w_advance   = w_run & ~bus.stall;
  assign w_load_zero = w_accept | w_wrap_i;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_wrap_i)  w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Limits are captured only on an accepted start so mid-pass changes are invisible.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_lim_i <= '0;
      r_lim_j <= '0;
      r_lim_k <= '0;
    end else if (w_accept) begin
      r_lim_i <= bus.limit_i;
      r_lim_j <= bus.limit_j;
      r_lim_k <= bus.limit_k;
    end
  end

  wrap_counter #(.WIDTH(WIDTH)) u_cnt_k (
    .clk       (clk),
    .clr       (clr),
    .en        (w_advance),
    .load_zero (w_load_zero),
    .limit     (r_lim_k),
    .count     (w_idx_k),
    .wrap      (w_wrap_k)
  );

  wrap_counter #(.WIDTH(WIDTH)) u_cnt_j (
    .clk       (clk),
    .clr       (clr),
    .en        (w_wrap_k),
    .load_zero (w_load_zero),
    .limit     (r_lim_j),
    .count     (w_idx_j),
    .wrap      (w_wrap_j)
  );

  wrap_counter #(.WIDTH(WIDTH)) u_cnt_i (
    .clk       (clk),
    .clr       (clr),
    .en        (w_wrap_j),
    .load_zero (w_load_zero),
    .limit     (r_lim_i),
    .count     (w_idx_i),
    .wrap      (w_wrap_i)
  );

  assign bus.idx_i   = w_idx_i;
  assign bus.idx_j   = w_idx_j;
  assign bus.idx_k   = w_idx_k;
  assign bus.valid   = w_run;
  assign bus.busy    = w_run;
  assign bus.done    = (r_state == ST_DONE);
  assign bus.first_k = w_run & (w_idx_k == '0);
  assign bus.last_k  = w_run & (w_idx_k == r_lim_k);

endmodule

// File: tb/tb_matrix_index_sequencer.sv
// Directed self-checking bench for matrix_index_sequencer (WIDTH=4).
module tb_matrix_index_sequencer;

  localparam int W = 4;

  logic clk;
  logic clr;
  int   n_checks;
  int   n_fail;

  matrix_index_sequencer_if #(.WIDTH(W)) bus ();

  matrix_index_sequencer #(.WIDTH(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_limits(input int li, input int lj, input int lk);
    bus.limit_i = W'(li);
    bus.limit_j = W'(lj);
    bus.limit_k = W'(lk);
  endtask

  task automatic check_quiet(input string tag, input logic exp_done);
    chk({tag, ".valid"}, 32'(bus.valid), 32'd0);
    chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".done"}, 32'(bus.done), 32'(exp_done));
    chk({tag, ".idx"}, {20'd0, bus.idx_i, bus.idx_j, bus.idx_k}, 32'd0);
    chk({tag, ".first_k"}, 32'(bus.first_k), 32'd0);
    chk({tag, ".last_k"}, 32'(bus.last_k), 32'd0);
  endtask

  task automatic check_beat(input int i, input int j, input int k, input int lk);
    chk("beat.valid", 32'(bus.valid), 32'd1);
    chk("beat.busy", 32'(bus.busy), 32'd1);
    chk("beat.done", 32'(bus.done), 32'd0);
    chk("beat.idx", {20'd0, bus.idx_i, bus.idx_j, bus.idx_k}, 32'((i << 8) | (j << 4) | k));
    chk("beat.first_k", 32'(bus.first_k), 32'(k == 0));
    chk("beat.last_k", 32'(bus.last_k), 32'(k == lk));
  endtask

  // Runs one full pass, checking every beat; optionally stalls at one beat or
  // hammers start/limits during the pass to prove they are ignored.
  task automatic run_pass(input int li, input int lj, input int lk,
                          input int stall_beat, input int stall_len, input bit noise);
    int beat;
    set_limits(li, lj, lk);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    beat = 0;
    for (int i = 0; i <= li; i++) begin
      for (int j = 0; j <= lj; j++) begin
        for (int k = 0; k <= lk; k++) begin
          check_beat(i, j, k, lk);
          if (noise) begin
            bus.start = 1'b1;
            set_limits(3, 3, 3);
          end
          if (beat == stall_beat) begin
            bus.stall = 1'b1;
            for (int s = 0; s < stall_len; s++) begin
              step();
              check_beat(i, j, k, lk);
            end
            bus.stall = 1'b0;
          end
          beat++;
          step();
        end
      end
    end
    check_quiet("done_cycle", 1'b1);
    bus.start = 1'b0;
    set_limits(0, 0, 0);
    step();
    check_quiet("after_done", 1'b0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    clr       = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    set_limits(0, 0, 0);
    step();
    step();
    check_quiet("reset", 1'b0);
    clr = 1'b0;

    // Stall and start in idle do nothing beyond the start itself.
    bus.stall = 1'b1;
    step();
    check_quiet("idle_stall", 1'b0);
    bus.stall = 1'b0;

    run_pass(1, 1, 1, -1, 0, 1'b0);
    run_pass(0, 0, 0, -1, 0, 1'b0);
    run_pass(0, 2, 3, 5, 3, 1'b0);

    // Mid-pass clear at the fifth beat (1,0,0).
    set_limits(1, 1, 1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int b = 0; b < 4; b++) step();
    check_beat(1, 0, 0, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_quiet("mid_clr", 1'b0);
    step();
    check_quiet("mid_clr_idle", 1'b0);
    run_pass(1, 1, 1, -1, 0, 1'b0);

    // Clear together with start wins.
    set_limits(1, 1, 1);
    clr = 1'b1;
    bus.start = 1'b1;
    step();
    clr = 1'b0;
    bus.start = 1'b0;
    check_quiet("clr_with_start", 1'b0);
    step();
    check_quiet("clr_with_start_idle", 1'b0);

    run_pass(1, 0, 1, -1, 0, 1'b1);
    run_pass(15, 15, 15, -1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
